// File: rtl/wb_collector_pkg.sv
// Shared types for the writeback collector: instruction id and unit index.
package wb_collector_pkg;

    localparam int ID_W          = 3;
    localparam int NUM_UNITS_DEF = 4;

    typedef logic [ID_W-1:0] id_t;

    // Index into the execution-unit vector; issue logic reuses this type.
    typedef logic [$clog2(NUM_UNITS_DEF)-1:0] unit_idx_t;

endpackage

// File: rtl/wb_collector_if.sv
// Writeback bus between the execution units and the collector, plus the registered result.
interface wb_collector_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32
);
    import wb_collector_pkg::*;

    logic [NUM_UNITS-1:0]           unit_done;
    id_t  [NUM_UNITS-1:0]           unit_id;
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_rd;
    logic [NUM_UNITS-1:0]           unit_ack;
    logic                           wb_valid;
    id_t                            wb_id;
    logic [XLEN-1:0]                wb_data;

    // Units side: presents results, consumes ack, observes the commit result.
    modport master (
        output unit_done, unit_id, unit_rd,
        input  unit_ack, wb_valid, wb_id, wb_data
    );

    // Collector side.
    modport slave (
        input  unit_done, unit_id, unit_rd,
        output unit_ack, wb_valid, wb_id, wb_data
    );

endinterface

// File: rtl/wb_collector_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr, pointer advances past the winner.
module wb_collector_rr_arbiter #(
    parameter  int NUM_UNITS = 4,
    localparam int IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] req,
    input  logic                 advance,
    output logic [NUM_UNITS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_vld
);

    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            logic [IDX_W:0]   sum;
            logic [IDX_W-1:0] idx;
            // One spare bit so rr_ptr + i cannot overflow before the modulo fold.
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_UNITS))
                sum = sum - (IDX_W+1)'(NUM_UNITS);
            idx = sum[IDX_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (advance && grant_vld) begin
            if (grant_idx == IDX_W'(NUM_UNITS - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_collector.sv
// Writeback collector: grants one finished unit per cycle round-robin and registers its id/data for commit.
module wb_collector
    import wb_collector_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_collector_if.slave wb
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;

    logic                 vld_p1;
    id_t                  id_p1;
    logic [XLEN-1:0]      data_p1;

    wb_collector_rr_arbiter #(
        .NUM_UNITS (NUM_UNITS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (wb.unit_done),
        .advance   (1'b1),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign wb.unit_ack = grant;

    // p0 -> p1: capture the granted unit's result; id/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= |wb.unit_done;
            if (grant_vld) begin
                id_p1   <= wb.unit_id[grant_idx];
                data_p1 <= wb.unit_rd[grant_idx];
            end
        end
    end

    assign wb.wb_valid = vld_p1;
    assign wb.wb_id    = id_p1;
    assign wb.wb_data  = data_p1;

endmodule

// File: doc/wb_collector.md
Name: wb_collector

Overview:
- Writeback-side counterpart of the execution units' writeback interface.
- Each cycle it collects completed results from NUM_UNITS execution units (mul, alu, div, load/store, ...) and grants at most one unit, using round-robin arbitration.
- It acknowledges the granted unit in the same cycle and presents a registered result (valid, id, data) to the register-file / commit stage one cycle later.

Parameters:
- NUM_UNITS, 4, number of execution units feeding the collector (2..8).
- XLEN, 32, result data width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- unit_done  input  NUM_UNITS  per-unit result-available flag (the unit's wb.done).
- unit_id  input  NUM_UNITS x $bits(id_t)  per-unit instruction id (the unit's wb.id).
- unit_rd  input  NUM_UNITS x XLEN  per-unit result data (the unit's wb.rd).
- unit_ack  output  NUM_UNITS  one-hot-or-zero grant (drives the unit's wb.ack).
- wb_valid  output  1  registered result valid to commit stage.
- wb_id  output  $bits(id_t)  registered id of the granted result.
- wb_data  output  XLEN  registered data of the granted result.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: wb_valid=0, wb_id=0, wb_data=0, round-robin pointer rr_ptr=0. unit_ack is combinational, so it is 0 whenever unit_done=0.
- Unit protocol, which the collector relies on:
  - A unit holds done, id and rd stable until it sees ack.
  - A unit drops done, or presents its next result, in the cycle after ack.
- Arbitration (combinational):
  - Search unit_done starting at index rr_ptr, wrapping modulo NUM_UNITS.
  - The first set bit is the grant g; unit_ack[g]=1 and all other ack bits are 0.
  - If no done bit is set, unit_ack=0.
  - Ack is never asserted toward a unit whose done=0.
- Pointer update on the clock edge:
  - If a grant occurred, rr_ptr <= (g+1) mod NUM_UNITS.
  - Otherwise rr_ptr holds.
  - Wrap: a grant to unit NUM_UNITS-1 sets rr_ptr=0.
- Output register on the clock edge:
  - wb_valid <= |unit_done.
  - When a grant occurs, wb_id <= unit_id[g] and wb_data <= unit_rd[g].
  - When no grant occurs, wb_id and wb_data hold their previous values; they are don't-care while wb_valid=0.
- Latency and throughput: 1 cycle from ack to wb_valid. Sustained throughput is 1 result per cycle with no bubbles while any unit is done.
- No backpressure: the commit stage always accepts wb_valid.
- Fairness: with every unit continuously done, each unit is granted exactly once every NUM_UNITS cycles, in index order.
- Simultaneous events: several units done in the same cycle gives exactly one grant; the others keep done asserted and wait.
- Reset mid-operation: rst has priority over all updates.
  - wb_valid clears on the next edge.
  - rr_ptr returns to 0.
  - A unit_ack raised combinationally in the reset cycle is permitted. The unit consumes its result, which is discarded; the units are reset by the same rst.
- Identity: the collector never modifies id or data; it is a pure selection.

Decomposition:
- id_t comes from the shared cva5_types package.
- A NUM_UNITS-based index type (unit_idx_t, $clog2(NUM_UNITS) bits) goes in the same package for reuse by issue logic.
- One sub-module is natural: rr_arbiter.
  - Parameter: NUM_UNITS.
  - Inputs: request vector, grant-advance enable.
  - Outputs: one-hot grant and binary grant index; holds rr_ptr internally.
  - Reusable by the issue stage.
- The top level owns the data mux and the output register.

Test Plan:
- Reset: hold rst 3 cycles with unit_done=4'b1111 -> wb_valid=0 during reset; after release, first grant to unit 0 (rr_ptr=0).
- Single unit: unit_done=4'b0100, id=5, rd=32'hDEAD_BEEF -> unit_ack=4'b0100 in the same cycle; next cycle wb_valid=1, wb_id=5, wb_data=32'hDEAD_BEEF, rr_ptr=3.
- Round-robin fairness: all four units done continuously with distinct ids 0..3 -> grant order 0,1,2,3,0,1,... with wb_valid=1 every cycle and no unit skipped.
- Wrap-around: rr_ptr=3, unit_done=4'b1001 -> grant unit 3, then unit 0 next cycle; rr_ptr goes 0, then 1.
- Idle gap: unit_done=0 for 2 cycles between results -> unit_ack=0, wb_valid=0 in the following cycles, rr_ptr unchanged.
- Mid-stream reset: rst asserted while 3 units are pending -> next edge wb_valid=0 and rr_ptr=0; after release, arbitration restarts from unit 0.
